mcycle_control: RTL and testbench
=================================

MCYCLE_CONTROL -- requirements
Module: mcycle_control

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 16, setting the data width and the num_inst counter width.
REQ-002 The block SHALL have port clk, input, 1 bit, the clock.
REQ-003 The block SHALL have port reset_cpu, input, 1 bit, the reset: asynchronous, active-high.
REQ-004 The block SHALL have port cpu_enable, input, 1 bit; when 0 the FSM freezes.
REQ-005 The block SHALL have port opcode, input, 4 bits, taken from the IR: inst[15:12].
REQ-006 The block SHALL have port func, input, 6 bits, taken from the IR: inst[5:0].
REQ-007 The block SHALL have port input_ready, input, 1 bit, the instruction-memory data-valid handshake.
REQ-008 The block SHALL have port read_m, output, 1 bit, the instruction fetch request.
REQ-009 The block SHALL have port ir_write, output, 1 bit, the IR load strobe.
REQ-010 The block SHALL have port pc_write, output, 1 bit, the PC update strobe.
REQ-011 The block SHALL have port pc_src, output, 1 bit: 0 selects pc+1, 1 selects {pc[15:12], inst[11:0]}.
REQ-012 The block SHALL have ports reg_write, reg_dst, alu_src and lhi, each output, 1 bit, the datapath controls.
REQ-013 The block SHALL have port wwd_strobe, output, 1 bit, the output-port latch pulse.
REQ-014 The block SHALL have port halted, output, 1 bit, high in HALT.
REQ-015 The block SHALL have port state, output, 3 bits, the current state encoding.
REQ-016 The block SHALL have port num_inst, output, WORD_SIZE bits, the count of completed instructions.

Function
REQ-017 States SHALL be IF=0, ID=1, EX=2, WB=3, HALT=4; all other encodings SHALL transition to IF on the next enabled edge.
REQ-018 Decode SHALL be: ADD = opcode 15 with func 0; WWD = opcode 15 with func 28; HLT = opcode 15 with func 29; ADI = opcode 4; LHI = opcode 6; JMP = opcode 9; any other combination is invalid.
REQ-019 IF: read_m=1; on an edge with cpu_enable=1 and input_ready=1, ir_write=1 during that cycle and the next state is ID; otherwise the FSM stays in IF (unbounded wait states).
REQ-020 ID with JMP: pc_write=1, pc_src=1, num_inst increments, next state is IF.
REQ-021 ID with WWD: wwd_strobe=1, pc_write=1, pc_src=0, num_inst increments, next state is IF.
REQ-022 ID with HLT: num_inst increments, no pc_write, next state is HALT.
REQ-023 ID with ADD, ADI or LHI: next state is EX.
REQ-024 ID with an invalid instruction: pc_write=1, pc_src=0, no increment of num_inst, next state is IF.
REQ-025 EX: alu_src=1 for ADI, else 0; lhi=1 for LHI; next state is WB.
REQ-026 WB: reg_write=1; reg_dst=1 for ADD, else 0; alu_src and lhi are held as in EX; pc_write=1, pc_src=0, num_inst increments, next state is IF.
REQ-027 Control outputs SHALL be combinational from state, opcode and func; opcode and func SHALL be treated as stable from ID through WB.
REQ-028 Every strobe (ir_write, pc_write, reg_write, wwd_strobe) SHALL be gated by cpu_enable and asserted for exactly one enabled cycle per transition.
REQ-029 With cpu_enable=0, state and num_inst SHALL hold, all strobes SHALL be 0, and read_m SHALL hold its state-decoded value.
REQ-030 HALT: halted=1, all strobes 0, read_m=0; the FSM SHALL remain in HALT until reset_cpu.
REQ-031 Latency with zero wait states SHALL be: ADD/ADI/LHI 4 cycles; JMP/WWD 2 cycles; HLT 2 cycles to reach HALT.
REQ-032 num_inst SHALL wrap modulo 2^WORD_SIZE from all-ones to 0.

Reset
REQ-033 reset_cpu=1 SHALL immediately force state=IF, num_inst=0, halted=0, and all strobes 0, regardless of clk or cpu_enable.
REQ-034 Reset asserted mid-instruction SHALL abort the instruction without pc_write or reg_write; on release, the fetch SHALL restart in IF.
REQ-035 While reset_cpu=1, read_m SHALL be 1 (state IF).

Verification
REQ-036 Scenario: opcode 6 (LHI), input_ready always 1 -> states IF, ID, EX, WB; reg_write pulse in cycle 4 with lhi=1 and reg_dst=0; num_inst goes 0 to 1.
REQ-037 Scenario: opcode 9 (JMP) -> pc_write=1 and pc_src=1 in ID; no reg_write; 2-cycle round trip to IF.
REQ-038 Scenario: input_ready held low for 3 cycles during IF -> stays in IF with read_m=1 and no ir_write; ir_write fires on the 4th cycle.
REQ-039 Scenario: cpu_enable dropped during EX for 5 cycles -> state stays 2 and no strobes; WB follows re-enable.
REQ-040 Scenario: opcode 15 with func 29 (HLT), then further clocks -> halted=1 and state=4 persist; reset_cpu pulse returns to IF with num_inst=0.
REQ-041 Scenario: reset_cpu pulsed asynchronously during WB of ADD -> no reg_write, state=0 without waiting for a clock edge.

Source files
------------

// File: rtl/mcycle_control_if.sv
// mcycle_control_if: instruction-handshake and datapath-control bundle
// between the multicycle control FSM and the rest of the CPU.
//   opcode, func    : instruction fields taken from the IR (inst[15:12], inst[5:0])
//   input_ready     : instruction-memory data-valid handshake
//   read_m          : instruction fetch request
//   ir_write        : IR load strobe
//   pc_write/pc_src : PC update strobe and source (0: pc+1, 1: jump target)
//   reg_write, reg_dst, alu_src, lhi : register-file / ALU controls
//   wwd_strobe      : output-port latch pulse
// modport master is the control unit, modport slave is the datapath side.
interface mcycle_control_if;
    logic [3:0] opcode;
    logic [5:0] func;
    logic       input_ready;
    logic       read_m;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src;
    logic       lhi;
    logic       wwd_strobe;

    modport master (
        input  opcode, func, input_ready,
        output read_m, ir_write, pc_write, pc_src,
               reg_write, reg_dst, alu_src, lhi, wwd_strobe
    );

    modport slave (
        output opcode, func, input_ready,
        input  read_m, ir_write, pc_write, pc_src,
               reg_write, reg_dst, alu_src, lhi, wwd_strobe
    );
endinterface

// File: rtl/mcycle_control.sv
// mcycle_control: multicycle CPU control FSM (IF -> ID -> EX -> WB, HALT).
// Ports:
//   clk        : clock
//   reset_cpu  : asynchronous active-high reset, forces IF and clears num_inst
//   cpu_enable : when low the FSM and counter freeze and every strobe is 0
//   bus        : instruction handshake and datapath controls (master side)
//   halted     : high while in HALT
//   state      : current state encoding (IF=0, ID=1, EX=2, WB=3, HALT=4)
//   num_inst   : count of completed instructions, wraps modulo 2^WORD_SIZE
// Control outputs are combinational from state, opcode and func; the IR
// holds opcode/func stable from ID through WB.
module mcycle_control #(
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 reset_cpu,
    input  logic                 cpu_enable,
    mcycle_control_if.master     bus,
    output logic                 halted,
    output logic [2:0]           state,
    output logic [WORD_SIZE-1:0] num_inst
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_WB   = 3'd3,
        S_HALT = 3'd4
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [WORD_SIZE-1:0]   num_inst_r;

    logic is_op15_s, is_add_s, is_wwd_s, is_hlt_s, is_adi_s, is_lhi_s, is_jmp_s;
    logic strobe_en_s;
    logic read_m_s, ir_req_s, pc_req_s, pc_src_s, reg_req_s, reg_dst_s;
    logic alu_src_s, lhi_s, wwd_req_s, done_req_s;

    assign is_op15_s = (bus.opcode == 4'd15);
    assign is_add_s  = is_op15_s && (bus.func == 6'd0);
    assign is_wwd_s  = is_op15_s && (bus.func == 6'd28);
    assign is_hlt_s  = is_op15_s && (bus.func == 6'd29);
    assign is_adi_s  = (bus.opcode == 4'd4);
    assign is_lhi_s  = (bus.opcode == 6'd6);
    assign is_jmp_s  = (bus.opcode == 4'd9);

    // Reset is included so strobes drop the instant reset_cpu rises,
    // before the state register has been observed as IF downstream.
    assign strobe_en_s = cpu_enable & ~reset_cpu;

    // State register: frozen while cpu_enable is low.
    always_ff @(posedge clk or posedge reset_cpu) begin
        if (reset_cpu) begin
            state_r <= S_IF;
        end else if (cpu_enable) begin
            state_r <= state_next_s;
        end else begin
            state_r <= state_r;
        end
    end

    // Completed-instruction counter; natural wrap at all-ones.
    always_ff @(posedge clk or posedge reset_cpu) begin
        if (reset_cpu) begin
            num_inst_r <= {WORD_SIZE{1'b0}};
        end else if (cpu_enable && done_req_s) begin
            num_inst_r <= num_inst_r + WORD_SIZE'(1);
        end else begin
            num_inst_r <= num_inst_r;
        end
    end

    // Next-state and ungated control decode.
    always_comb begin
        state_next_s = state_r;
        read_m_s     = 1'b0;
        ir_req_s     = 1'b0;
        pc_req_s     = 1'b0;
        pc_src_s     = 1'b0;
        reg_req_s    = 1'b0;
        reg_dst_s    = 1'b0;
        alu_src_s    = 1'b0;
        lhi_s        = 1'b0;
        wwd_req_s    = 1'b0;
        done_req_s   = 1'b0;
        case (state_r)
            S_IF: begin
                read_m_s = 1'b1;
                if (bus.input_ready) begin
                    ir_req_s     = 1'b1;
                    state_next_s = S_ID;
                end else begin
                    state_next_s = S_IF;
                end
            end
            S_ID: begin
                if (is_jmp_s) begin
                    pc_req_s     = 1'b1;
                    pc_src_s     = 1'b1;
                    done_req_s   = 1'b1;
                    state_next_s = S_IF;
                end else if (is_wwd_s) begin
                    wwd_req_s    = 1'b1;
                    pc_req_s     = 1'b1;
                    done_req_s   = 1'b1;
                    state_next_s = S_IF;
                end else if (is_hlt_s) begin
                    done_req_s   = 1'b1;
                    state_next_s = S_HALT;
                end else if (is_add_s || is_adi_s || is_lhi_s) begin
                    state_next_s = S_EX;
                end else begin
                    // Invalid instruction: skip it without counting.
                    pc_req_s     = 1'b1;
                    state_next_s = S_IF;
                end
            end
            S_EX: begin
                alu_src_s    = is_adi_s;
                lhi_s        = is_lhi_s;
                state_next_s = S_WB;
            end
            S_WB: begin
                reg_req_s    = 1'b1;
                reg_dst_s    = is_add_s;
                alu_src_s    = is_adi_s;
                lhi_s        = is_lhi_s;
                pc_req_s     = 1'b1;
                done_req_s   = 1'b1;
                state_next_s = S_IF;
            end
            S_HALT: begin
                state_next_s = S_HALT;
            end
            default: begin
                state_next_s = S_IF;
            end
        endcase
    end

    assign bus.read_m     = read_m_s;
    assign bus.ir_write   = ir_req_s  & strobe_en_s;
    assign bus.pc_write   = pc_req_s  & strobe_en_s;
    assign bus.reg_write  = reg_req_s & strobe_en_s;
    assign bus.wwd_strobe = wwd_req_s & strobe_en_s;
    assign bus.pc_src     = pc_src_s;
    assign bus.reg_dst    = reg_dst_s;
    assign bus.alu_src    = alu_src_s;
    assign bus.lhi        = lhi_s;

    assign halted   = (state_r == S_HALT);
    assign state    = state_r;
    assign num_inst = num_inst_r;

endmodule

// File: tb/tb_mcycle_control.sv
// tb_mcycle_control: scoreboard bench for mcycle_control. Expected
// state/control/counter values are pushed when stimulus is applied and
// popped and compared when the DUT outputs are sampled (negedge, or #1
// after an asynchronous reset edge). A 4-bit counter makes wrap reachable.
module tb_mcycle_control;

    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;

    // Control vector bit order:
    // {read_m, ir_write, pc_write, pc_src, reg_write, reg_dst, alu_src, lhi, wwd_strobe, halted}
    localparam logic [9:0] C_IF_GO   = 10'b1100000000;
    localparam logic [9:0] C_IF_WAIT = 10'b1000000000;
    localparam logic [9:0] C_NONE    = 10'b0000000000;
    localparam logic [9:0] C_ID_JMP  = 10'b0011000000;
    localparam logic [9:0] C_ID_WWD  = 10'b0010000010;
    localparam logic [9:0] C_ID_BAD  = 10'b0010000000;
    localparam logic [9:0] C_EX_ADI  = 10'b0000001000;
    localparam logic [9:0] C_EX_LHI  = 10'b0000000100;
    localparam logic [9:0] C_WB_ADD  = 10'b0010110000;
    localparam logic [9:0] C_WB_ADI  = 10'b0010101000;
    localparam logic [9:0] C_WB_LHI  = 10'b0010100100;
    localparam logic [9:0] C_HALT    = 10'b0000000001;

    logic         clk;
    logic         reset_cpu;
    logic         cpu_enable;
    logic         halted;
    logic [2:0]   state;
    logic [W-1:0] num_inst;
    logic [9:0]   obs_ctl;

    mcycle_control_if bus();

    mcycle_control #(.WORD_SIZE(W)) dut (
        .clk        (clk),
        .reset_cpu  (reset_cpu),
        .cpu_enable (cpu_enable),
        .bus        (bus.master),
        .halted     (halted),
        .state      (state),
        .num_inst   (num_inst)
    );

    assign obs_ctl = {bus.read_m, bus.ir_write, bus.pc_write, bus.pc_src,
                      bus.reg_write, bus.reg_dst, bus.alu_src, bus.lhi,
                      bus.wwd_strobe, halted};

    typedef struct {
        string       tag;
        logic [2:0]  st;
        logic [9:0]  ctl;
        logic [31:0] ni;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_inst  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [2:0] st, input logic [9:0] ctl, input int ni);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        e.ctl = ctl;
        e.ni  = 32'(ni & MASK);
        sb.push_back(e);
    endtask

    task automatic compare_front();
        exp_t e;
        e = sb.pop_front();
        check_eq({e.tag, "_state"}, 32'(state),    32'(e.st));
        check_eq({e.tag, "_ctl"},   32'(obs_ctl),  32'(e.ctl));
        check_eq({e.tag, "_num"},   32'(num_inst), e.ni);
    endtask

    // Check the current cycle at negedge, then advance past the next posedge.
    task automatic cyc(input string tag, input logic [2:0] st, input logic [9:0] ctl, input int ni);
        push_exp(tag, st, ctl, ni);
        @(negedge clk);
        compare_front();
        @(posedge clk);
        #1;
    endtask

    task automatic check_now(input string tag, input logic [2:0] st, input logic [9:0] ctl, input int ni);
        push_exp(tag, st, ctl, ni);
        compare_front();
    endtask

    // One instruction with zero wait states; expectations follow the decode table.
    task automatic do_inst(input string name, input logic [3:0] op, input logic [5:0] fn);
        bus.opcode      = op;
        bus.func        = fn;
        bus.input_ready = 1'b1;
        cyc({name, "_IF"}, 3'd0, C_IF_GO, n_inst);
        if (op == 4'd9) begin
            cyc({name, "_ID"}, 3'd1, C_ID_JMP, n_inst);
            n_inst++;
        end else if (op == 4'd15 && fn == 6'd28) begin
            cyc({name, "_ID"}, 3'd1, C_ID_WWD, n_inst);
            n_inst++;
        end else if ((op == 4'd15 && fn == 6'd0) || op == 4'd4 || op == 4'd6) begin
            cyc({name, "_ID"}, 3'd1, C_NONE, n_inst);
            if (op == 4'd4) begin
                cyc({name, "_EX"}, 3'd2, C_EX_ADI, n_inst);
                cyc({name, "_WB"}, 3'd3, C_WB_ADI, n_inst);
            end else if (op == 4'd6) begin
                cyc({name, "_EX"}, 3'd2, C_EX_LHI, n_inst);
                cyc({name, "_WB"}, 3'd3, C_WB_LHI, n_inst);
            end else begin
                cyc({name, "_EX"}, 3'd2, C_NONE, n_inst);
                cyc({name, "_WB"}, 3'd3, C_WB_ADD, n_inst);
            end
            n_inst++;
        end else begin
            cyc({name, "_ID"}, 3'd1, C_ID_BAD, n_inst);
        end
    endtask

    initial begin
        reset_cpu       = 1'b1;
        cpu_enable      = 1'b1;
        bus.opcode      = 4'd0;
        bus.func        = 6'd0;
        bus.input_ready = 1'b1;

        // Reset state: IF, read_m high, no ir_write despite input_ready.
        #2;
        check_now("RST", 3'd0, C_IF_WAIT, 0);
        @(posedge clk);
        #1;
        check_now("RST_edge", 3'd0, C_IF_WAIT, 0);
        reset_cpu = 1'b0;

        // Main decode paths.
        do_inst("LHI", 4'd6, 6'd0);
        check_eq("LHI_count", 32'(num_inst), 32'd1);
        do_inst("JMP", 4'd9, 6'd0);
        do_inst("ADD", 4'd15, 6'd0);
        do_inst("ADI", 4'd4, 6'd0);
        do_inst("WWD", 4'd15, 6'd28);
        do_inst("BAD1", 4'd0, 6'd0);
        do_inst("BAD2", 4'd15, 6'd5);

        // Wait states in IF.
        bus.opcode      = 4'd9;
        bus.input_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("IF_wait", 3'd0, C_IF_WAIT, n_inst);
        bus.input_ready = 1'b1;
        cyc("IF_go", 3'd0, C_IF_GO, n_inst);
        cyc("JMPw_ID", 3'd1, C_ID_JMP, n_inst);
        n_inst++;

        // Freeze in IF: read_m stays, no ir_write.
        cpu_enable = 1'b0;
        bus.opcode = 4'd4;
        for (int i = 0; i < 2; i++) cyc("IF_frz", 3'd0, C_IF_WAIT, n_inst);
        cpu_enable = 1'b1;

        // Freeze in EX of ADI for 5 cycles.
        cyc("ADIf_IF", 3'd0, C_IF_GO, n_inst);
        cyc("ADIf_ID", 3'd1, C_NONE, n_inst);
        cpu_enable = 1'b0;
        for (int i = 0; i < 5; i++) cyc("EX_frz", 3'd2, C_EX_ADI, n_inst);
        cpu_enable = 1'b1;
        cyc("ADIf_EX", 3'd2, C_EX_ADI, n_inst);
        cyc("ADIf_WB", 3'd3, C_WB_ADI, n_inst);
        n_inst++;

        // Asynchronous reset during WB of ADD.
        bus.opcode = 4'd15;
        bus.func   = 6'd0;
        cyc("ADDr_IF", 3'd0, C_IF_GO, n_inst);
        cyc("ADDr_ID", 3'd1, C_NONE, n_inst);
        cyc("ADDr_EX", 3'd2, C_NONE, n_inst);
        #1;
        check_now("ADDr_WB", 3'd3, C_WB_ADD, n_inst);
        reset_cpu = 1'b1;
        #1;
        n_inst = 0;
        check_now("RST_WB", 3'd0, C_IF_WAIT, n_inst);
        @(posedge clk);
        #1;
        check_now("RST_WB_hold", 3'd0, C_IF_WAIT, n_inst);
        reset_cpu = 1'b0;
        do_inst("JMPr", 4'd9, 6'd0);

        // HLT: two cycles to HALT, then sticky until reset.
        bus.opcode = 4'd15;
        bus.func   = 6'd29;
        cyc("HLT_IF", 3'd0, C_IF_GO, n_inst);
        cyc("HLT_ID", 3'd1, C_NONE, n_inst);
        n_inst++;
        for (int i = 0; i < 3; i++) cyc("HALT", 3'd4, C_HALT, n_inst);
        reset_cpu = 1'b1;
        #1;
        n_inst = 0;
        check_now("RST_HALT", 3'd0, C_IF_WAIT, n_inst);
        @(posedge clk);
        #1;
        reset_cpu = 1'b0;

        // Counter wrap: 20 completions on a 4-bit counter.
        for (int i = 0; i < 20; i++) do_inst("JMPw", 4'd9, 6'd0);
        check_eq("wrap_num", 32'(num_inst), 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
